// File: rtl/dz_count_ctrl_pkg.sv
// Shared definitions for the count-game digit sequencer: FSM state encoding,
// digit code width and small elaboration helpers.
package dz_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_FLASH  = 2'd3
  } dz_state_e;

  localparam int DZ_NUM_W = 3;

  function automatic int dz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dz_prescaler.sv
// Clock-divider counter shared by the countdown and flash phases. The terminal
// value is a run-time input so one instance can serve both divide ratios.
module dz_prescaler #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div_m1,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = en && (count == div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == div_m1) count <= '0;
      else                 count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown/flash sequencer feeding the digit-select and blank inputs of the
// dot-matrix row-scan driver; runs on the driver's scan clock.
module dz_count_ctrl
  import dz_count_ctrl_pkg::*;
#(
  parameter int START_NUM    = 6,
  parameter int TICK_DIV     = 1000,
  parameter int BLINK_DIV    = 250,
  parameter int FLASH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] disp_num,
  output logic       disp_blank,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int PRE_W = $clog2(dz_max(TICK_DIV, BLINK_DIV));
  localparam int PH_W  = $clog2(2 * FLASH_CYCLES + 1);

  localparam logic [PRE_W-1:0]    TICK_M1    = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]    BLINK_M1   = PRE_W'(BLINK_DIV - 1);
  localparam logic [PH_W-1:0]     PH_LAST    = PH_W'(2 * FLASH_CYCLES - 1);
  localparam logic [DZ_NUM_W-1:0] START_V    = DZ_NUM_W'(START_NUM);
  localparam bit                  START_ZERO = (START_NUM == 0);

  generate
    if (START_NUM < 0 || START_NUM > 7) begin : g_bad_start
      $error("dz_count_ctrl: START_NUM must be 0..7");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
      $error("dz_count_ctrl: TICK_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
      $error("dz_count_ctrl: BLINK_DIV must be >= 1");
    end
    if (FLASH_CYCLES < 1) begin : g_bad_flash
      $error("dz_count_ctrl: FLASH_CYCLES must be >= 1");
    end
  endgenerate

  dz_state_e         state;
  logic              start_q;
  logic [PH_W-1:0]   phase;
  logic              start_rise;
  logic              pre_clr;
  logic              pre_en;
  logic [PRE_W-1:0]  pre_div_m1;
  logic [PRE_W-1:0]  pre_count;
  logic              pre_tc;

  assign start_rise = start & ~start_q;

  // The resume edge out of PAUSED counts, so a pause costs exactly its own length.
  assign pre_clr    = start_rise || (state == ST_IDLE);
  assign pre_en     = (((state == ST_COUNT) || (state == ST_PAUSED)) && !pause)
                      || (state == ST_FLASH);
  assign pre_div_m1 = (state == ST_FLASH) ? BLINK_M1 : TICK_M1;

  dz_prescaler #(
    .W (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pre_clr),
    .en     (pre_en),
    .div_m1 (pre_div_m1),
    .count  (pre_count),
    .tc     (pre_tc)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      phase      <= '0;
      disp_num   <= '0;
      disp_blank <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (start_rise) begin
        disp_num <= START_V;
        phase    <= '0;
        busy     <= 1'b1;
        if (START_ZERO) begin
          state      <= ST_FLASH;
          disp_blank <= 1'b1;
        end else begin
          state      <= ST_COUNT;
          disp_blank <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_COUNT, ST_PAUSED: begin
            if (pause) begin
              state <= ST_PAUSED;
            end else begin
              state <= ST_COUNT;
              if (pre_tc) begin
                // Digit 1 never decrements to 0 here; reaching 0 always enters FLASH.
                if (disp_num > 3'd1) begin
                  disp_num <= disp_num - 1'b1;
                end else begin
                  disp_num   <= '0;
                  state      <= ST_FLASH;
                  disp_blank <= 1'b1;
                  phase      <= '0;
                end
              end
            end
          end
          ST_FLASH: begin
            if (pre_tc) begin
              if (phase == PH_LAST) begin
                state      <= ST_IDLE;
                disp_blank <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                phase      <= '0;
              end else begin
                phase      <= phase + 1'b1;
                disp_blank <= ~disp_blank;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
